// File: rtl/add_sub_serial_param.sv
// Digit-serial adder/subtractor. Operands are loaded (with XOR masks) on accept, processed
// DIGIT bits per cycle LSB-first, with optional pre/post delay states and a ready/done handshake.
module add_sub_serial_param #(
  parameter int               WIDTH      = 16,
  parameter int               DIGIT      = 1,
  parameter logic [WIDTH-1:0] A_MASK     = '0,
  parameter logic [WIDTH-1:0] B_MASK     = '0,
  parameter int               PRE_DELAY  = 1,
  parameter int               POST_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int N         = WIDTH / DIGIT;
  localparam int CNT_MAX   = (N > 8) ? N : 8;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int PRE_LAST  = (PRE_DELAY > 0) ? PRE_DELAY - 1 : 0;
  localparam int POST_LAST = (POST_DELAY > 0) ? POST_DELAY - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ADD,
    S_POST,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg, b_reg, out_reg;
  logic             carry_reg, cout_reg, ovf_reg;
  logic             accept;

  // Digit ripple: c[i] is the carry into bit i of the current digit.
  wire [DIGIT:0]   c;
  wire [DIGIT-1:0] dsum;
  assign c[0] = carry_reg;
  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_ripple
    assign dsum[gi]  = a_reg[gi] ^ b_reg[gi] ^ c[gi];
    assign c[gi+1]   = (a_reg[gi] & b_reg[gi]) | (c[gi] & (a_reg[gi] ^ b_reg[gi]));
  end

  wire pre_last  = (cnt_reg == CW'(PRE_LAST));
  wire add_last  = (cnt_reg == CW'(N - 1));
  wire post_last = (cnt_reg == CW'(POST_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (PRE_DELAY > 0) ? S_PRE : S_ADD;
        end
      end
      S_PRE:   if (pre_last) state_next = S_ADD;
      S_ADD:   if (add_last) state_next = (POST_DELAY > 0) ? S_POST : S_DONE;
      S_POST:  if (post_last) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      out_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
      a_reg     <= a ^ A_MASK;
      b_reg     <= sub ? ~(b ^ B_MASK) : (b ^ B_MASK);
      carry_reg <= sub;
      out_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_PRE:  cnt_reg <= pre_last ? '0 : cnt_reg + CW'(1);
        S_POST: cnt_reg <= post_last ? '0 : cnt_reg + CW'(1);
        S_ADD: begin
          out_reg   <= (out_reg >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
          a_reg     <= a_reg >> DIGIT;
          b_reg     <= b_reg >> DIGIT;
          carry_reg <= c[DIGIT];
          cnt_reg   <= add_last ? '0 : cnt_reg + CW'(1);
          if (add_last) begin
            cout_reg <= c[DIGIT];
            ovf_reg  <= c[DIGIT-1] ^ c[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign done  = (state_reg == S_DONE);
  assign out   = out_reg;
  assign cout  = cout_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_add_sub_serial_param.sv
// Self-checking bench: four configurations of add_sub_serial_param driven with directed and
// random operations, compared against a plain-arithmetic reference model.
module tb_add_sub_serial_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  start_v = '0;
  logic [3:0]  sub_v = '0;
  logic [15:0] a_v [4];
  logic [15:0] b_v [4];
  wire  [3:0]  ready_v, done_v, cout_v, ovf_v;
  wire  [7:0]  out0, out2;
  wire  [15:0] out1, out3;

  int nvec = 0;
  int nerr = 0;

  // Per-instance configuration mirrored for the model.
  int          w_c    [4] = '{8, 16, 8, 16};
  int          d_c    [4] = '{1, 4, 2, 8};
  int          pre_c  [4] = '{1, 0, 3, 7};
  int          post_c [4] = '{1, 0, 2, 0};
  logic [15:0] am_c   [4] = '{16'h0, 16'h0, 16'h5E, 16'h0};
  logic [15:0] bm_c   [4] = '{16'h0, 16'h0, 16'h0, 16'hA5C3};

  always #5 clk = ~clk;

  add_sub_serial_param #(.WIDTH(8), .DIGIT(1), .A_MASK(8'h00), .B_MASK(8'h00),
                         .PRE_DELAY(1), .POST_DELAY(1)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
    .ready(ready_v[0]), .done(done_v[0]), .out(out0), .cout(cout_v[0]), .ovf(ovf_v[0]));

  add_sub_serial_param #(.WIDTH(16), .DIGIT(4), .A_MASK(16'h0), .B_MASK(16'h0),
                         .PRE_DELAY(0), .POST_DELAY(0)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]), .a(a_v[1]), .b(b_v[1]),
    .ready(ready_v[1]), .done(done_v[1]), .out(out1), .cout(cout_v[1]), .ovf(ovf_v[1]));

  add_sub_serial_param #(.WIDTH(8), .DIGIT(2), .A_MASK(8'h5E), .B_MASK(8'h00),
                         .PRE_DELAY(3), .POST_DELAY(2)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v[2]), .a(a_v[2][7:0]), .b(b_v[2][7:0]),
    .ready(ready_v[2]), .done(done_v[2]), .out(out2), .cout(cout_v[2]), .ovf(ovf_v[2]));

  add_sub_serial_param #(.WIDTH(16), .DIGIT(8), .A_MASK(16'h0), .B_MASK(16'hA5C3),
                         .PRE_DELAY(7), .POST_DELAY(0)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .sub(sub_v[3]), .a(a_v[3]), .b(b_v[3]),
    .ready(ready_v[3]), .done(done_v[3]), .out(out3), .cout(cout_v[3]), .ovf(ovf_v[3]));

  function automatic logic [15:0] out_of(input int k);
    case (k)
      0:       return {8'h00, out0};
      1:       return out1;
      2:       return {8'h00, out2};
      default: return out3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: masked operands, then ordinary modular add/subtract with signed-overflow rules.
  task automatic model(input int k, input logic [15:0] a, input logic [15:0] b, input logic s,
                       output logic [15:0] r, output logic c, output logic v);
    longint mw, ad, bd, res;
    int w;
    logic sa, sb, sr;
    w  = w_c[k];
    mw = (longint'(1) << w) - 1;
    ad = longint'(a ^ am_c[k]) & mw;
    bd = longint'(b ^ bm_c[k]) & mw;
    if (s) begin
      res = (ad - bd) & mw;
      c   = (ad >= bd);
    end else begin
      res = (ad + bd) & mw;
      c   = (((ad + bd) >> w) & 1) != 0;
    end
    sa = ((ad >> (w - 1)) & 1) != 0;
    sb = ((bd >> (w - 1)) & 1) != 0;
    sr = ((res >> (w - 1)) & 1) != 0;
    v  = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    r  = 16'(res);
  endtask

  // One transaction; with flood=1, start stays high with fresh junk operands while busy.
  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic s,
                        input bit flood);
    logic [15:0] er;
    logic ec, ev;
    int lat, guard, exp_lat;
    model(k, a, b, s, er, ec, ev);
    exp_lat = pre_c[k] + w_c[k] / d_c[k] + post_c[k];
    guard = 0;
    while (!ready_v[k] && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    @(negedge clk);
    start_v[k] = 1'b1; a_v[k] = a; b_v[k] = b; sub_v[k] = s;
    @(posedge clk); #1;
    start_v[k] = flood;
    a_v[k] = 16'($urandom); b_v[k] = 16'($urandom); sub_v[k] = 1'($urandom);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1; lat++;
      if (done_v[k]) break;
      a_v[k] = 16'($urandom); b_v[k] = 16'($urandom); sub_v[k] = 1'($urandom);
    end
    start_v[k] = 1'b0;
    if (!done_v[k]) lat = 999;
    chk($sformatf("d%0d latency a=%h b=%h sub=%0d", k, a, b, s), lat, exp_lat);
    chk($sformatf("d%0d out a=%h b=%h sub=%0d", k, a, b, s), out_of(k), er);
    chk($sformatf("d%0d cout a=%h b=%h sub=%0d", k, a, b, s), cout_v[k], ec);
    chk($sformatf("d%0d ovf a=%h b=%h sub=%0d", k, a, b, s), ovf_v[k], ev);
    $display("d%0d a=%h b=%h sub=%0d -> out=%h cout=%0d ovf=%0d lat=%0d", k, a, b, s,
             out_of(k), cout_v[k], ovf_v[k], lat);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin a_v[k] = '0; b_v[k] = '0; end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("d%0d reset out", k), out_of(k), 16'h0);
      chk($sformatf("d%0d reset ready/done/cout/ovf", k),
          {ready_v[k], done_v[k], cout_v[k], ovf_v[k]}, 4'b1000);
    end
    @(negedge clk); rst = 1'b0;

    // Directed vectors from the feature list.
    run_op(0, 16'h5A, 16'h3C, 1'b0, 1'b0);
    chk("d0 const 5A+3C", {out_of(0), 6'b0, cout_v[0], ovf_v[0]}, {16'h0096, 8'b01});
    repeat (3) @(posedge clk);
    #1;
    chk("d0 hold in DONE", {out_of(0), 7'b0, done_v[0]}, {16'h0096, 8'h01});
    run_op(0, 16'hFF, 16'h01, 1'b0, 1'b0);
    chk("d0 const FF+01", {out_of(0), 6'b0, cout_v[0], ovf_v[0]}, {16'h0000, 8'b10});
    run_op(0, 16'h10, 16'h20, 1'b1, 1'b0);
    chk("d0 const 10-20", {out_of(0), 6'b0, cout_v[0], ovf_v[0]}, {16'h00F0, 8'b00});
    run_op(1, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    chk("d1 const 1234+0FFF", out_of(1), 16'h2233);
    run_op(1, 16'h8000, 16'h0001, 1'b1, 1'b0);
    chk("d1 const 8000-0001", {out_of(1), 6'b0, cout_v[1], ovf_v[1]}, {16'h7FFF, 8'b11});
    run_op(2, 16'h00, 16'h01, 1'b0, 1'b0);
    chk("d2 const mask add", out_of(2), 16'h005F);
    run_op(2, 16'h5E, 16'h01, 1'b1, 1'b0);
    chk("d2 const mask sub", out_of(2), 16'h00FF);

    // Start held high while busy must not disturb the accepted operation.
    run_op(0, 16'h5A, 16'h3C, 1'b0, 1'b1);
    run_op(2, 16'hC3, 16'h7E, 1'b1, 1'b1);

    // Asynchronous reset during the third ADD cycle of u0 (PRE is one cycle).
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 16'hFF; b_v[0] = 16'hFF; sub_v[0] = 1'b0;
    @(posedge clk); #1; start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst = 1'b1; #1;
    chk("d0 abort out", out_of(0), 16'h0);
    chk("d0 abort ready/done/cout/ovf", {ready_v[0], done_v[0], cout_v[0], ovf_v[0]}, 4'b1000);
    @(negedge clk); rst = 1'b0;
    run_op(0, 16'h01, 16'h02, 1'b0, 1'b0);
    chk("d0 const after abort", out_of(0), 16'h0003);

    // Random traffic on every configuration, some with start flooding.
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < 4; k++) begin
        run_op(k, 16'($urandom) & 16'((32'h1 << w_c[k]) - 1),
                  16'($urandom) & 16'((32'h1 << w_c[k]) - 1),
                  1'($urandom), bit'(i % 4 == 3));
      end
    end
    // Extremes for signed overflow in both directions.
    run_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op(1, 16'h8000, 16'hFFFF, 1'b0, 1'b0);
    run_op(3, 16'h0000, 16'h0000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/add_sub_serial_param.md
Name: add_sub_serial_param

Overview:
Parametrised digit-serial adder/subtractor, the next generation of the team's 8-bit bit-serial adder. It generalises operand width and digit size (bits per cycle), and adds subtract mode, carry-out, signed overflow, a ready/done handshake and per-operand XOR load masks. It also supports configurable pre- and post-computation delay states. It sits between a register-file style producer and consumer in control-path datapaths.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT, and WIDTH >= 2.
DIGIT, 1, bits processed per ADD cycle; valid values are 1, 2, 4 and 8.
A_MASK, 0, WIDTH-bit XOR mask applied to a at load.
B_MASK, 0, WIDTH-bit XOR mask applied to b at load.
PRE_DELAY, 1, number of PRE cycles between accept and the first ADD cycle; valid range 0..7.
POST_DELAY, 1, number of POST cycles between the last ADD cycle and DONE; valid range 0..7.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-high.
start  input  1  request; sampled only when ready=1.
sub  input  1  0 = add, 1 = subtract; captured at accept.
a  input  WIDTH  operand A; captured at accept.
b  input  WIDTH  operand B; captured at accept.
ready  output  1  high in IDLE and DONE.
done  output  1  high while in DONE.
out  output  WIDTH  result.
cout  output  1  final carry; for subtract, 1 means no borrow.
ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (rst=1, asynchronous, active-high, clock clk): state=IDLE, out=0, cout=0, ovf=0, all internal registers 0, ready=1, done=0. Reset asserted mid-operation aborts the operation immediately; no partial result is retained.
- States: IDLE, PRE, ADD, POST, DONE.
- Accept occurs on a rising edge where start=1 and ready=1. At accept:
  - a_reg <= a ^ A_MASK.
  - b_reg <= (b ^ B_MASK), inverted when sub=1.
  - carry <= sub.
  - out, cout, ovf <= 0.
  - cnt <= 0.
  - Next state is PRE if PRE_DELAY > 0, otherwise ADD.
- start while ready=0 is ignored and has no side effects. start=0 in DONE holds DONE and the result indefinitely. start=1 in DONE is a new accept.
- PRE: stays for PRE_DELAY cycles, then goes to ADD. Registers hold.
- ADD: each cycle processes one digit, for N = WIDTH/DIGIT cycles.
  - s = a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry, computed as a (DIGIT+1)-bit ripple.
  - out <= {s[DIGIT-1:0], out[WIDTH-1:DIGIT]}, i.e. LSB digit first, shifted in from the top.
  - a_reg and b_reg shift right by DIGIT.
  - carry <= s[DIGIT].
  - cnt increments each cycle.
  - On the cycle with cnt == N-1:
    - cout <= s[DIGIT].
    - ovf <= (carry into bit DIGIT-1 of the digit) ^ s[DIGIT].
    - Next state is POST if POST_DELAY > 0, otherwise DONE.
- POST: stays for POST_DELAY cycles, then goes to DONE. out, cout and ovf hold.
- Latency: done rises exactly PRE_DELAY + N + POST_DELAY rising edges after the accept edge. out, cout and ovf are final and stable whenever done=1.
- The counter is reused for the PRE, ADD and POST counts and is wide enough for max(N, 8).
- Arithmetic is modulo 2^WIDTH. out is not meaningful while ready=0.
- ready and done are combinational decodes of state only.

Test Plan:
- WIDTH=8, DIGIT=1, PRE=1, POST=1; accept a=0x5A, b=0x3C, sub=0 -> done rises 10 edges after accept; out=0x96, cout=0, ovf=1.
- Same config: a=0xFF, b=0x01, add -> out=0x00, cout=1, ovf=0. Then, from DONE, accept a=0x10, b=0x20, sub=1 -> out=0xF0, cout=0, ovf=0. Check the back-to-back accept from DONE works.
- WIDTH=16, DIGIT=4, PRE=0, POST=0: a=0x1234, b=0x0FFF, add -> done after 4 edges; out=0x2233, cout=0. Then a=0x8000, b=0x0001, sub=1 -> out=0x7FFF, ovf=1, cout=1.
- WIDTH=8, A_MASK=0x5E, B_MASK=0x00: a=0x00, b=0x01, add -> out=0x5F. Then a=0x5E, b=0x01, sub=1 -> out=0xFF.
- Pulse start=1 on every cycle while busy, with changing a and b -> result matches the first accepted operands only; done timing is unchanged.
- Assert rst for 1 cycle during the 3rd ADD cycle -> out, cout, ovf become 0 immediately; ready=1, done=0. A subsequent accept of 0x01+0x02 gives out=0x03 with nominal latency.
